// File: rtl/mips_pkg.sv
// Shared encodings and the per-stage control bundle for the MIPS control pipeline.
package mips_pkg;

  // Instruction register fields are 5 bits wide, so stage destinations are kept at 5 bits.
  localparam int DST_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_OR = 2'b10} alu_op_e;
  typedef enum logic [1:0] {NPC_SEQ = 2'b00, NPC_BR = 2'b01, NPC_JIMM = 2'b10, NPC_JREG = 2'b11} npc_op_e;
  typedef enum logic [1:0] {EXT_ZERO = 2'b00, EXT_SIGN = 2'b01, EXT_UPPER = 2'b10} ext_op_e;
  typedef enum logic [1:0] {M2R_ALU = 2'b00, M2R_LOAD = 2'b01, M2R_SLT = 2'b10, M2R_LINK = 2'b11} mem_to_reg_e;
  typedef enum logic [1:0] {BR_NONE = 2'b00, BR_EQ = 2'b01, BR_NE = 2'b10} br_type_e;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10} fwd_sel_e;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic [DST_W-1:0] dst;
    logic             mem_write;
    mem_to_reg_e      mem_to_reg;
    logic             alu_src;
    alu_op_e          alu_op;
    npc_op_e          npc_op;
    logic             is_load;
    br_type_e         br_type;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // A stage produces a value a consumer reads; register 0 never matches.
  function automatic logic src_hit(ctrl_t c, logic used, logic [DST_W-1:0] src);
    return used && (src != '0) && c.valid && c.reg_write && (c.dst == src);
  endfunction

  // Whether the instruction in EX takes a non-sequential path this cycle.
  function automatic logic redirects(ctrl_t c, logic zero);
    logic jump;
    jump = (c.npc_op == NPC_JIMM) || (c.npc_op == NPC_JREG);
    return c.valid && (jump || (c.br_type == BR_EQ && zero) || (c.br_type == BR_NE && !zero));
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control-unit <-> datapath signal bundle. The datapath is the master.
interface pipe_ctrl_if #(parameter int REG_AW = 5);
  logic [31:0]       instr_id;
  logic              id_valid;
  logic              ex_zero;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic [1:0]        id_ext_op;
  logic              id_illegal;
  logic              ex_alu_src;
  logic [1:0]        ex_alu_op;
  logic [1:0]        ex_npc_op;
  logic              ex_redirect;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              mem_write;
  logic              wb_reg_write;
  logic [1:0]        wb_mem_to_reg;
  logic [REG_AW-1:0] wb_dst;

  modport master (
    output instr_id, id_valid, ex_zero,
    input  pc_en, ifid_en, ifid_flush, id_ext_op, id_illegal, ex_alu_src, ex_alu_op,
           ex_npc_op, ex_redirect, fwd_a, fwd_b, mem_write, wb_reg_write, wb_mem_to_reg, wb_dst
  );

  modport slave (
    input  instr_id, id_valid, ex_zero,
    output pc_en, ifid_en, ifid_flush, id_ext_op, id_illegal, ex_alu_src, ex_alu_op,
           ex_npc_op, ex_redirect, fwd_a, fwd_b, mem_write, wb_reg_write, wb_mem_to_reg, wb_dst
  );
endinterface

// File: rtl/pipe_decode.sv
// Combinational instruction decoder: instruction word to control bundle and source usage.
module pipe_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output ext_op_e     ext_op,
  output logic        use_rs,
  output logic        use_rt,
  output logic        illegal
);

  logic [5:0]       op;
  logic [5:0]       fn;
  logic [DST_W-1:0] rt;
  logic [DST_W-1:0] rd;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign rt = instr[20:16];
  assign rd = instr[15:11];

  // Decode opcode/funct; anything outside the supported set becomes a harmless NOP.
  always_comb begin
    ctrl       = CTRL_BUBBLE;
    ctrl.valid = 1'b1;
    ext_op     = EXT_SIGN;
    use_rs     = 1'b0;
    use_rt     = 1'b0;
    illegal    = 1'b0;
    case (op)
      OP_RTYPE: begin
        use_rs   = 1'b1;
        use_rt   = 1'b1;
        ctrl.dst = rd;
        case (fn)
          FN_ADDU: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_ADD; end
          FN_SUBU: begin ctrl.reg_write = 1'b1; ctrl.alu_op = ALU_SUB; end
          FN_SLT: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_op     = ALU_SUB;
            ctrl.mem_to_reg = M2R_SLT;
          end
          FN_JR: begin ctrl.dst = '0; ctrl.npc_op = NPC_JREG; end
          default: illegal = 1'b1;
        endcase
      end
      OP_ORI: begin
        use_rs = 1'b1; ctrl.dst = rt; ctrl.reg_write = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_OR; ext_op = EXT_ZERO;
      end
      // lui ORs the upper-shifted immediate into zero; rs is not read.
      OP_LUI: begin
        ctrl.dst = rt; ctrl.reg_write = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_OR; ext_op = EXT_UPPER;
      end
      OP_ADDI, OP_ADDIU: begin
        use_rs = 1'b1; ctrl.dst = rt; ctrl.reg_write = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD;
      end
      OP_LW: begin
        use_rs = 1'b1; ctrl.dst = rt; ctrl.reg_write = 1'b1; ctrl.is_load = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD; ctrl.mem_to_reg = M2R_LOAD;
      end
      OP_SW: begin
        use_rs = 1'b1; use_rt = 1'b1; ctrl.mem_write = 1'b1;
        ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_ADD;
      end
      OP_BEQ: begin
        use_rs = 1'b1; use_rt = 1'b1;
        ctrl.alu_op = ALU_SUB; ctrl.npc_op = NPC_BR; ctrl.br_type = BR_EQ;
      end
      OP_BNE: begin
        use_rs = 1'b1; use_rt = 1'b1;
        ctrl.alu_op = ALU_SUB; ctrl.npc_op = NPC_BR; ctrl.br_type = BR_NE;
      end
      OP_J: ctrl.npc_op = NPC_JIMM;
      OP_JAL: begin
        ctrl.npc_op = NPC_JIMM; ctrl.reg_write = 1'b1;
        ctrl.dst = '1; ctrl.mem_to_reg = M2R_LINK;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      ctrl       = CTRL_BUBBLE;
      ctrl.valid = 1'b1;
      ext_op     = EXT_SIGN;
      use_rs     = 1'b0;
      use_rt     = 1'b0;
    end
    if (ctrl.dst == '0) ctrl.reg_write = 1'b0;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: decode, ID/EX/MEM/WB control registers, hazards, forwarding, redirect.
module pipe_ctrl
  import mips_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter bit EN_FWD = 1'b1
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);

  ctrl_t            id_ctrl;
  ext_op_e          id_ext;
  logic             id_use_rs, id_use_rt, id_bad;
  logic [DST_W-1:0] id_rs, id_rt;

  ctrl_t            ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;
  logic [DST_W-1:0] ex_rs_d, ex_rs_q, ex_rt_d, ex_rt_q;
  logic             ex_use_rs_d, ex_use_rs_q, ex_use_rt_d, ex_use_rt_q;

  logic             ex_hit, mem_hit, stall, redirect;
  fwd_sel_e         fwd_a, fwd_b;

  assign id_rs = bus.instr_id[25:21];
  assign id_rt = bus.instr_id[20:16];

  pipe_decode u_decode (
    .instr   (bus.instr_id),
    .ctrl    (id_ctrl),
    .ext_op  (id_ext),
    .use_rs  (id_use_rs),
    .use_rt  (id_use_rt),
    .illegal (id_bad)
  );

  // Stall and redirect decisions; a redirect overrides a stall and squashes ID.
  always_comb begin
    ex_hit   = src_hit(ex_q, id_use_rs, id_rs) || src_hit(ex_q, id_use_rt, id_rt);
    mem_hit  = src_hit(mem_q, id_use_rs, id_rs) || src_hit(mem_q, id_use_rt, id_rt);
    // Without forwarding, WB needs no stall because the regfile writes through.
    if (EN_FWD) stall = bus.id_valid && ex_q.is_load && ex_hit;
    else        stall = bus.id_valid && (ex_hit || mem_hit);
    redirect = redirects(ex_q, bus.ex_zero);
  end

  // ID/EX loads the decoded instruction, or a bubble on stall, redirect or empty ID.
  always_comb begin
    ex_d        = id_ctrl;
    ex_rs_d     = id_rs;
    ex_rt_d     = id_rt;
    ex_use_rs_d = id_use_rs;
    ex_use_rt_d = id_use_rt;
    if (!bus.id_valid || stall || redirect) begin
      ex_d        = CTRL_BUBBLE;
      ex_rs_d     = '0;
      ex_rt_d     = '0;
      ex_use_rs_d = 1'b0;
      ex_use_rt_d = 1'b0;
    end
    mem_d = ex_q;
    wb_d  = mem_q;
  end

  // EX operand sources; the MEM producer is younger than WB, so it wins.
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (EN_FWD) begin
      if (src_hit(mem_q, ex_use_rs_q, ex_rs_q))     fwd_a = FWD_MEM;
      else if (src_hit(wb_q, ex_use_rs_q, ex_rs_q)) fwd_a = FWD_WB;
      if (src_hit(mem_q, ex_use_rt_q, ex_rt_q))     fwd_b = FWD_MEM;
      else if (src_hit(wb_q, ex_use_rt_q, ex_rt_q)) fwd_b = FWD_WB;
    end
  end

  // Stage control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= CTRL_BUBBLE;
      mem_q       <= CTRL_BUBBLE;
      wb_q        <= CTRL_BUBBLE;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_use_rs_q <= 1'b0;
      ex_use_rt_q <= 1'b0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_use_rs_q <= ex_use_rs_d;
      ex_use_rt_q <= ex_use_rt_d;
    end
  end

  assign bus.pc_en         = redirect || !stall;
  assign bus.ifid_en       = redirect || !stall;
  assign bus.ifid_flush    = redirect;
  assign bus.id_ext_op     = id_ext;
  assign bus.id_illegal    = bus.id_valid && id_bad;
  assign bus.ex_alu_src    = ex_q.alu_src;
  assign bus.ex_alu_op     = ex_q.alu_op;
  assign bus.ex_npc_op     = ex_q.npc_op;
  assign bus.ex_redirect   = redirect;
  assign bus.fwd_a         = fwd_a;
  assign bus.fwd_b         = fwd_b;
  assign bus.mem_write     = mem_q.valid && mem_q.mem_write;
  assign bus.wb_reg_write  = wb_q.valid && wb_q.reg_write;
  assign bus.wb_mem_to_reg = wb_q.mem_to_reg;
  // The link register is all-ones at the configured width, not just at the field width.
  assign bus.wb_dst        = (wb_q.valid && wb_q.mem_to_reg == M2R_LINK) ? '1 : REG_AW'(wb_q.dst);

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipelined control unit for the 5-stage MIPS core. It decodes the instruction held in the IF/ID register and carries the resulting control bundle through its own ID/EX, EX/MEM and MEM/WB control registers. It detects load-use and RAW hazards, producing stall and bubble controls, and resolves branches and jumps in EX with a two-slot flush. It also drives the EX operand-forwarding selects. The datapath owns all data registers; this block owns only control state.

## Interface
Parameters:
- `REG_AW`, 5: register-address width; link register is all-ones (`$31` at default).
- `EN_FWD`, 1: 1 = forwarding plus load-use stall only; 0 = no forwarding, stall on any RAW against EX or MEM.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `instr_id`  in  32  instruction in IF/ID.
- `id_valid`  in  1  IF/ID holds a real instruction.
- `ex_zero`  in  1  ALU zero flag of the EX instruction.
- `pc_en`  out  1  PC load enable.
- `ifid_en`  out  1  IF/ID load enable.
- `ifid_flush`  out  1  IF/ID loads a bubble next edge.
- `id_ext_op`  out  2  immediate extend: 00 zero, 01 sign, 10 upper.
- `id_illegal`  out  1  valid ID instruction not in the decode set.
- `ex_alu_src`, `ex_alu_op[1:0]`  out  control for the EX instruction (alu_op: 00 add, 01 sub, 10 or).
- `ex_npc_op`  out  2  00 seq, 01 branch, 10 jump-imm, 11 jump-reg.
- `ex_redirect`  out  1  EX instruction redirects PC this cycle.
- `fwd_a`, `fwd_b`  out  2 each  EX operand source: 00 regfile, 01 MEM stage, 10 WB stage.
- `mem_write`  out  1  store in MEM.
- `wb_reg_write`  out  1  regfile write in WB.
- `wb_mem_to_reg`  out  2  00 ALU, 01 load, 10 slt flag, 11 link PC+8.
- `wb_dst`  out  REG_AW  WB destination.

## Operation
- Decode set: addu, subu, slt, jr, ori, lw, sw, beq, bne, lui, jal, j, addi, addiu.
- Any other opcode/funct decodes as NOP with no write, no store and no redirect, and raises `id_illegal` for that cycle.
- Destinations: rd for R-type, rt for I-type writes, all-ones for jal.
- Source usage: rs for all but lui/j/jal; rt for R-type, sw, beq, bne.
- Writes to register 0 are forced to `reg_write=0`. Sources equal to 0 never hazard or forward.
- Load-use hazard (EN_FWD=1): EX is valid lw, its dst≠0, and dst equals a used ID source.
  - Response: `pc_en=0`, `ifid_en=0`, and ID/EX loads a bubble.
- RAW hazard (EN_FWD=0): a used ID source equals a valid writing dst in EX or MEM.
  - Response: same as load-use. The regfile is write-through, so WB never stalls.
- Forwarding (EN_FWD=1): MEM match takes priority over WB match, so the youngest producer wins. EN_FWD=0 ties `fwd_a`/`fwd_b` to 00.
- Redirect: `ex_redirect` = valid EX and one of:
  - j, jal or jr;
  - beq and `ex_zero`;
  - bne and not `ex_zero`.
- On redirect:
  - `ifid_flush=1`, and ID/EX loads a bubble (2-slot penalty).
  - `pc_en=1`; the datapath selects the target by `ex_npc_op`.
  - The redirecting instruction itself continues to MEM/WB, so jal writes its link.
- Redirect and stall in the same cycle: redirect wins, and the stalled ID instruction is squashed.
- Bubble: all write/store/redirect controls 0 and valid 0.

## Timing
- Decode outputs (`id_*`) and hazard outputs (`pc_en`, `ifid_*`, `fwd_*`, `ex_redirect`) are combinational from current state.
- Stage controls appear in EX 1 cycle after ID, MEM after 2, WB after 3, absent stalls.
- A stall holds ID for exactly 1 cycle per load-use with EN_FWD=1, and up to 2 cycles with EN_FWD=0.
- Reset (asynchronous, any time, including mid-stall or mid-redirect): all stage valids and registered controls clear to 0. Combinational outputs then read `pc_en=1`, `ifid_en=1`, `ifid_flush=0`, `fwd_*=00`, `ex_redirect=0`, `wb_dst=0`.
- The first instruction after reset release reaches WB on the 4th edge.

## Structure
- Shared package `mips_pkg`:
  - opcode/funct constants;
  - `alu_op`, `npc_op`, `ext_op` and `mem_to_reg` encodings;
  - packed struct `ctrl_t` holding the per-stage bundle (valid, reg_write, dst, mem_write, mem_to_reg, alu_src, alu_op, npc_op, is_load, branch type).
- Sub-module `pipe_decode`: combinational, `instr` → `ctrl_t` plus source-use flags and `illegal`. The top holds three `ctrl_t` registers plus hazard, forward and redirect logic.

## Test plan
- `addu $3,$1,$2` then `subu $4,$3,$1` (EN_FWD=1) → `fwd_a=01` with subu in EX, no stall.
- `lw $5,0($1)` then `addu $6,$5,$5` → one cycle `pc_en=0`, `ifid_en=0`, bubble in EX; then `fwd_a=fwd_b=10`.
- `beq` with `ex_zero=1` → `ex_redirect=1`, `ifid_flush=1`, two bubbles; with `ex_zero=0` → no flush; bne gives the inverse.
- `jal` → `ex_npc_op=10`, redirect; 2 cycles later `wb_dst=31`, `wb_mem_to_reg=11`, `wb_reg_write=1`.
- Opcode 6'h3F → `id_illegal=1`, no write or store downstream. `addiu $0,$1,4` → `wb_reg_write=0`.
- EN_FWD=0, `ori $2,...` then `addu $3,$2,$2` → 2 stall cycles. Assert `rst_n=0` during the second → all outputs at reset values asynchronously.
